// File: rtl/debug_scan_pkg.sv
// Shared types and helpers for the debug scan bridge: FSM state encoding,
// status bit positions in the capture word, and IR channel count.
package debug_scan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } scan_state_e;

    function automatic int num_ir(input int ir_width);
        return 1 << ir_width;
    endfunction

    // Status bits overlay the top of every captured word.
    function automatic int stat_ovf_bit(input int dr_width);
        return dr_width - 1;
    endfunction

    function automatic int stat_pend_bit(input int dr_width);
        return dr_width - 2;
    endfunction

endpackage

// File: rtl/debug_scan_cmd_slot.sv
// Single-entry valid/ready command holding register; an issue that finds the
// slot occupied and not being drained is dropped and flagged in sticky overflow.
module debug_scan_cmd_slot #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue,
    input  logic [DR_WIDTH-1:0] issue_data,
    input  logic [IR_WIDTH-1:0] issue_ir,
    input  logic                issue_short,
    input  logic                cmd_ready,
    input  logic                ovf_clr,
    output logic                cmd_valid,
    output logic [DR_WIDTH-1:0] jdo,
    output logic [IR_WIDTH-1:0] cmd_ir,
    output logic                cmd_short,
    output logic                overflow,
    output logic                valid_next
);

    logic accept;
    logic drop;

    always_comb begin
        accept     = issue & (~cmd_valid | cmd_ready);
        drop       = issue & cmd_valid & ~cmd_ready;
        valid_next = cmd_valid;
        if (accept) begin
            valid_next = 1'b1;
        end else if (cmd_valid && cmd_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            jdo       <= '0;
            cmd_ir    <= '0;
            cmd_short <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cmd_valid <= valid_next;
            if (accept) begin
                jdo       <= issue_data;
                cmd_ir    <= issue_ir;
                cmd_short <= issue_short;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_scan_bridge.sv
// System-clock JTAG debug DR engine: per-IR capture/shift register and scan FSM,
// with completed scans handed to a single-entry command slot.
module debug_scan_bridge
    import debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int CNT_W    = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 vs_cdr,
    input  logic                                 vs_sdr,
    input  logic                                 vs_udr,
    input  logic                                 vs_uir,
    input  logic                                 jtag_rti,
    input  logic [IR_WIDTH-1:0]                  ir_in,
    input  logic                                 tdi,
    input  logic [num_ir(IR_WIDTH)*DR_WIDTH-1:0] capture_data,
    input  logic                                 ovf_clr,
    input  logic                                 cmd_ready,
    output logic                                 tdo,
    output logic                                 cmd_valid,
    output logic [DR_WIDTH-1:0]                  jdo,
    output logic [IR_WIDTH-1:0]                  cmd_ir,
    output logic                                 cmd_short,
    output logic                                 overflow,
    output logic                                 st_ready_test_idle
);

    localparam int OVF_BIT  = stat_ovf_bit(DR_WIDTH);
    localparam int PEND_BIT = stat_pend_bit(DR_WIDTH);

    scan_state_e         state;
    scan_state_e         state_next;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] cap_word;
    logic [IR_WIDTH-1:0] ir_q;
    logic [CNT_W-1:0]    shift_cnt;
    logic                shifting;
    logic                issue;
    logic                issue_short;
    logic                valid_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture wins over update so a cdr+udr cycle ends in SHIFT.
    always_comb begin
        state_next = state;
        if (vs_cdr) begin
            state_next = SHIFT;
        end else if (vs_udr && state == SHIFT) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        shifting    = (state == SHIFT);
        issue       = vs_udr & shifting;
        issue_short = (shift_cnt != CNT_W'(DR_WIDTH));
    end

    always_comb begin
        cap_word           = capture_data[int'(ir_q)*DR_WIDTH +: DR_WIDTH];
        cap_word[OVF_BIT]  = overflow;
        cap_word[PEND_BIT] = cmd_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr                 <= '0;
            ir_q               <= '0;
            shift_cnt          <= '0;
            st_ready_test_idle <= 1'b0;
        end else begin
            if (vs_uir) begin
                ir_q <= ir_in;
            end
            if (vs_cdr) begin
                sr        <= cap_word;
                shift_cnt <= '0;
            end else if (vs_sdr) begin
                sr <= {tdi, sr[DR_WIDTH-1:1]};
                if (shifting && shift_cnt != '1) begin
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end
            st_ready_test_idle <= jtag_rti & ~valid_next;
        end
    end

    assign tdo = sr[0];

    // The slot samples sr/shift_cnt before this cycle's cdr/sdr take effect.
    debug_scan_cmd_slot #(
        .DR_WIDTH (DR_WIDTH),
        .IR_WIDTH (IR_WIDTH)
    ) u_cmd_slot (
        .clk         (clk),
        .reset       (reset),
        .issue       (issue),
        .issue_data  (sr),
        .issue_ir    (ir_q),
        .issue_short (issue_short),
        .cmd_ready   (cmd_ready),
        .ovf_clr     (ovf_clr),
        .cmd_valid   (cmd_valid),
        .jdo         (jdo),
        .cmd_ir      (cmd_ir),
        .cmd_short   (cmd_short),
        .overflow    (overflow),
        .valid_next  (valid_next)
    );

endmodule

// File: tb/tb_debug_scan_bridge.sv
// Directed bench for debug_scan_bridge: expected commands are queued at issue
// and compared by a monitor on each valid/ready transfer.
module tb_debug_scan_bridge;

    localparam int DR = 38;
    localparam int IRW = 2;
    localparam int NIR = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, vs_uir = 1'b0;
    logic              jtag_rti = 1'b0;
    logic [IRW-1:0]    ir_in = '0;
    logic              tdi = 1'b0;
    logic [NIR*DR-1:0] capture_data = '0;
    logic              ovf_clr = 1'b0;
    logic              cmd_ready = 1'b0;
    logic              tdo, cmd_valid, cmd_short, overflow, st_ready_test_idle;
    logic [DR-1:0]     jdo;
    logic [IRW-1:0]    cmd_ir;

    typedef struct packed {
        logic [DR-1:0]  data;
        logic [IRW-1:0] ir;
        logic           short_scan;
    } cmd_t;

    cmd_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [DR-1:0] CAP2   = 38'h0_1234_5678;
    localparam logic [DR-1:0] PAT0   = 38'h2A_AAAA_AAAA;
    localparam logic [DR-1:0] SHORTX = {10'b1100110101, 28'h0048D15};
    localparam logic [DR-1:0] PAT_A  = 38'h3F_0F0F_0F0F;
    localparam logic [DR-1:0] PAT_B  = 38'h01_2345_6789;
    localparam logic [DR-1:0] PAT_C  = 38'h15_5555_0000;
    localparam logic [DR-1:0] PAT_D  = 38'h2B_CDEF_0123;
    localparam logic [DR-1:0] PAT_E  = 38'h00_0000_0001;
    localparam logic [DR-1:0] PAT_G  = 38'h12_3400_ABCD;

    debug_scan_bridge #(
        .DR_WIDTH (DR),
        .IR_WIDTH (IRW),
        .CNT_W    (6)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .vs_cdr             (vs_cdr),
        .vs_sdr             (vs_sdr),
        .vs_udr             (vs_udr),
        .vs_uir             (vs_uir),
        .jtag_rti           (jtag_rti),
        .ir_in              (ir_in),
        .tdi                (tdi),
        .capture_data       (capture_data),
        .ovf_clr            (ovf_clr),
        .cmd_ready          (cmd_ready),
        .tdo                (tdo),
        .cmd_valid          (cmd_valid),
        .jdo                (jdo),
        .cmd_ir             (cmd_ir),
        .cmd_short          (cmd_short),
        .overflow           (overflow),
        .st_ready_test_idle (st_ready_test_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transfers complete at the next posedge when valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cmd_unexpected: got jdo=%h ir=%0d short=%0b, expected no command",
                         jdo, cmd_ir, cmd_short);
            end else begin
                cmd_t e;
                e = exp_q.pop_front();
                if (jdo !== e.data || cmd_ir !== e.ir || cmd_short !== e.short_scan) begin
                    miscompares++;
                    $display("FAIL cmd_data: got jdo=%h ir=%0d short=%0b, expected jdo=%h ir=%0d short=%0b",
                             jdo, cmd_ir, cmd_short, e.data, e.ir, e.short_scan);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_uir(input logic [IRW-1:0] v);
        ir_in = v; vs_uir = 1'b1; tick(); vs_uir = 1'b0;
    endtask

    task automatic do_cdr();
        vs_cdr = 1'b1; tick(); vs_cdr = 1'b0;
    endtask

    task automatic do_udr();
        vs_udr = 1'b1; tick(); vs_udr = 1'b0;
    endtask

    task automatic shift_bits(input logic [DR-1:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            tdi = bits[i]; vs_sdr = 1'b1; tick(); vs_sdr = 1'b0;
        end
        tdi = 1'b0;
    endtask

    task automatic accept();
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    endtask

    task automatic push(input logic [DR-1:0] d, input logic [IRW-1:0] ir, input logic s);
        cmd_t c;
        c.data = d; c.ir = ir; c.short_scan = s;
        exp_q.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_jdo"}, 64'(jdo), 64'd0);
        check({tag, "_ir"}, 64'(cmd_ir), 64'd0);
        check({tag, "_short"}, 64'(cmd_short), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        check({tag, "_rti"}, 64'(st_ready_test_idle), 64'd0);
        check({tag, "_tdo"}, 64'(tdo), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Full scan on IR2: tdo streams the capture word, tdi pattern becomes jdo.
        capture_data[2*DR +: DR] = CAP2;
        do_uir(2'd2);
        do_cdr();
        for (int i = 0; i < DR; i++) begin
            logic [DR-1:0] cap;
            cap = CAP2;
            if (tdo !== cap[i]) begin
                check($sformatf("tdo_bit%0d", i), 64'(tdo), 64'(cap[i]));
            end
            tdi = PAT0[i]; vs_sdr = 1'b1; tick(); vs_sdr = 1'b0;
        end
        check("tdo_stream_done", 64'(tdo), 64'(PAT0[0]));
        push(PAT0, 2'd2, 1'b0);
        check("full_valid_before", 64'(cmd_valid), 64'd0);
        do_udr();
        check("full_valid_latency", 64'(cmd_valid), 64'd1);
        accept();
        check("full_valid_drained", 64'(cmd_valid), 64'd0);

        // Short scan: 10 shifts leave the tdi bits in jdo[37:28].
        do_cdr();
        shift_bits({28'd0, 10'b1100110101}, 10);
        push(SHORTX, 2'd2, 1'b1);
        do_udr();
        check("short_flag", 64'(cmd_short), 64'd1);
        accept();

        // Back-pressure: second scan is dropped, first held, overflow set.
        capture_data[1*DR +: DR] = 38'h15_0000_00FF;
        do_uir(2'd1);
        do_cdr(); shift_bits(PAT_A, DR);
        push(PAT_A, 2'd1, 1'b0);
        do_udr();
        do_cdr(); shift_bits(PAT_B, DR); do_udr();
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_jdo_held", 64'(jdo), 64'(PAT_A));
        check("bp_valid_held", 64'(cmd_valid), 64'd1);

        // Capture on IR0 (slice 0) shows status bits {overflow, pending} = 2'b11.
        do_uir(2'd0);
        do_cdr();
        check("status_bit0", 64'(tdo), 64'd0);
        shift_bits('0, 36);
        check("status_pend_bit", 64'(tdo), 64'd1);
        shift_bits('0, 1);
        check("status_ovf_bit", 64'(tdo), 64'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        accept();
        check("bp_drained", 64'(cmd_valid), 64'd0);

        // Same-cycle accept and issue: slot refills without dropping.
        do_cdr(); shift_bits(PAT_C, DR);
        push(PAT_C, 2'd0, 1'b0);
        do_udr();
        do_cdr(); shift_bits(PAT_D, DR);
        push(PAT_D, 2'd0, 1'b0);
        cmd_ready = 1'b1; vs_udr = 1'b1; tick(); vs_udr = 1'b0; cmd_ready = 1'b0;
        check("same_cycle_valid", 64'(cmd_valid), 64'd1);
        check("same_cycle_jdo", 64'(jdo), 64'(PAT_D));
        check("same_cycle_ovf", 64'(overflow), 64'd0);
        accept();

        // udr in IDLE is ignored; ready-test-idle follows rti and pending.
        jtag_rti = 1'b1;
        do_udr();
        check("idle_udr_valid", 64'(cmd_valid), 64'd0);
        check("idle_udr_ovf", 64'(overflow), 64'd0);
        check("rti_ready", 64'(st_ready_test_idle), 64'd1);
        do_cdr(); shift_bits(PAT_E, DR);
        push(PAT_E, 2'd0, 1'b0);
        do_udr();
        check("rti_pending_valid", 64'(cmd_valid), 64'd1);
        check("rti_pending", 64'(st_ready_test_idle), 64'd0);
        accept();
        tick();
        check("rti_ready_again", 64'(st_ready_test_idle), 64'd1);

        // Reset mid-scan with a pending command discards everything.
        do_cdr(); shift_bits(PAT_G, DR); do_udr();
        check("pre_reset_valid", 64'(cmd_valid), 64'd1);
        do_cdr(); shift_bits(PAT_B, 20);
        reset = 1'b1; tick(); reset = 1'b0;
        check_all_zero("midreset");
        do_udr();
        check("post_reset_udr_valid", 64'(cmd_valid), 64'd0);
        check("post_reset_udr_ovf", 64'(overflow), 64'd0);
        jtag_rti = 1'b0;
        repeat (2) tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
